// File: rtl/sram_model_sync.sv
// sram_model_sync: single-port SRAM model with a shared read/write address and a registered or combinational read.
// Define SRAM_WR_FWD_EN to make a same-edge read and write return the written data (sync mode only).
module sram_model_sync #(
  parameter int ADDR_WIDTH         = 8,
  parameter int DATA_WIDTH         = 8,
  parameter int RAM_IS_SYNCHRONOUS = 1
) (
  input  logic                  ramclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);
  logic [DATA_WIDTH-1:0] ram [0:2**ADDR_WIDTH-1] = '{default: '0};
  logic [DATA_WIDTH-1:0] rdat_q = '0;
  logic [DATA_WIDTH-1:0] rdat_d;
  always_ff @(posedge ramclk)
    if (!rst && wen) ram[addr] <= wdat;
`ifdef SRAM_WR_FWD_EN
  always_comb rdat_d = rst ? '0 : !ren ? rdat_q : wen ? wdat : ram[addr];
`else
  always_comb rdat_d = rst ? '0 : ren ? ram[addr] : rdat_q;
`endif
  always_ff @(posedge ramclk) rdat_q <= rdat_d;
  // Combinational read deliberately ignores rst.
  assign rdat = (RAM_IS_SYNCHRONOUS != 0) ? rdat_q : ren ? ram[addr] : '0;
endmodule

// File: tb/tb_sram_model_sync.sv
// tb_sram_model_sync: scoreboard bench driving a sync and an async instance with identical stimulus.
module tb_sram_model_sync;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 2**AW;
`ifdef SRAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdat = '0;
  logic [DW-1:0] rdat_s, rdat_a;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rd_m = '0;
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_model_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_IS_SYNCHRONOUS(1)) dut_s (
    .ramclk(clk), .rst(rst), .addr(addr), .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat_s));
  sram_model_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_IS_SYNCHRONOUS(0)) dut_a (
    .ramclk(clk), .rst(rst), .addr(addr), .wen(wen), .ren(ren), .wdat(wdat), .rdat(rdat_a));

  task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    dut_s.ram[a] = d;
    dut_a.ram[a] = d;
    mem_m[a] = d;
  endtask

  // One clock of stimulus: model the expected registered read and queue it for the monitor.
  task automatic cyc(input logic r, input logic w, input logic e,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst = r; wen = w; ren = e; addr = a; wdat = d;
    #1;
    chk("async_pre", rdat_a, e ? mem_m[a] : '0);
    if (r) rd_m = '0;
    else if (e) rd_m = (FWD && w) ? d : mem_m[a];
    if (!r && w) mem_m[a] = d;
    exp_q.push_back(rd_m);
    @(posedge clk);
    #1;
    chk("async_post", rdat_a, e ? mem_m[a] : '0);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) chk("sync_rdat", rdat_s, exp_q.pop_front());
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 5'd9, 8'h00);
    cyc(0, 1, 0, 5'd3, 8'hA5);
    cyc(0, 0, 1, 5'd3, 8'h00);
    cyc(0, 0, 0, 5'd3, 8'h00);
    cyc(0, 0, 0, 5'd6, 8'h00);
    poke(7, 8'h3C);
    cyc(0, 0, 1, 5'd7, 8'h00);
    cyc(0, 1, 0, 5'd31, 8'h11);
    chk("ram31_sync", dut_s.ram[31], 8'h11);
    chk("ram31_async", dut_a.ram[31], 8'h11);
    cyc(0, 0, 1, 5'd3, 8'h00);
    cyc(1, 1, 1, 5'd3, 8'hFF);
    chk("ram3_after_rst", dut_s.ram[3], 8'hA5);
    cyc(0, 0, 1, 5'd3, 8'h00);
    cyc(0, 0, 1, 5'd31, 8'h00);
    poke(4, 8'h10);
    cyc(0, 1, 1, 5'd4, 8'h20);
    chk("ram4_collide", dut_s.ram[4], 8'h20);
    cyc(0, 0, 0, 5'd4, 8'h00);
    poke(2, 8'h55);
    cyc(0, 0, 1, 5'd2, 8'h00);
    cyc(0, 0, 0, 5'd2, 8'h00);
    cyc(0, 1, 1, 5'd2, 8'h66);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, AW'(i + 8), DW'($urandom));
      cyc(0, 0, 1, AW'(i + 8), DW'($urandom));
    end
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
          AW'($urandom), DW'($urandom));
    rst = 0; wen = 0; ren = 0;
    @(posedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
